rvv_alu_rs_issue: RTL and testbench
===================================

// Module: rvv_alu_rs_issue
// PURPOSE
//  EX-side reader of the 2W2R ALU reservation station (RS). Peeks the two oldest RS entries and
//  generates pop0/pop1 for the RS. Loads the popped uops into two registered ALU issue lanes.
//  Each lane presents a valid/ready handshake toward its ALU datapath.
//  Sits between the ALU RS FIFO and the two ALU execution lanes.
// PARAMETERS
//  DWIDTH      `ALU_RS_WIDTH  width of one ALU_RS_t uop
//  CNT_W       16             width of the issued-uop performance counter (saturating)
// PORTS
//  clk                         in   1       clock, all state on rising edge
//  rst                         in   1       asynchronous, active-high reset
//  alu_uop0_rs2ex              in   DWIDTH  RS head entry (oldest)
//  alu_uop1_rs2ex              in   DWIDTH  RS head+1 entry
//  fifo_empty_rs2ex            in   1       RS holds 0 entries
//  fifo_1left_to_empty_rs2ex   in   1       RS holds exactly 1 entry
//  pop0_ex2rs                  out  1       pop RS head this cycle
//  pop1_ex2rs                  out  1       pop RS head+1 this cycle (only with pop0)
//  flush                       in   1       trap/kill: discard lane contents, suppress pops
//  lane0_valid / lane1_valid   out  1       lane holds a uop for the ALU
//  lane0_uop / lane1_uop       out  DWIDTH  registered uop per lane
//  lane0_ready / lane1_ready   in   1       ALU lane accepts; fire = valid & ready
//  issue_cnt                   out  CNT_W   total uops fired to ALU lanes, saturates at all-ones
// BEHAVIOUR
//  Reset: lane*_valid=0, lane*_uop=0, issue_cnt=0. pop*_ex2rs=0 while rst is high.
//  avail: 0 if fifo_empty; 1 if fifo_1left_to_empty; otherwise 2.
//  Lane state: EMPTY/FULL per lane. freeN = !laneN_valid | (laneN_valid & laneN_ready).
//  nfree is the number of free lanes (0..2).
//  Load, when flush=0: n = min(nfree, avail); n entries are taken oldest-first.
//   - n=2: head->lane0, head+1->lane1; pop0=pop1=1.
//   - n=1: head->lowest-index free lane; pop0=1, pop1=0.
//   - n=0: no pops; lanes with valid & !ready hold uop and valid stable.
//  Invariant: pop1 is never 1 unless pop0 is 1. No pop is issued when avail=0.
//  pop0/pop1 are combinational from lane state, ready, and RS flags. The RS pops at the same edge.
//  Latency: a uop at RS head in cycle N is lane output in cycle N+1; zero bubbles if ready stays high.
//  Ordering: within one load cycle, lane0 receives the older uop when both lanes load.
//  Lane on fire without reload: valid falls to 0 next cycle.
//  Lane on fire with reload in the same cycle: new uop next cycle, valid stays 1.
//  Flush: pops forced to 0 that cycle; both lanes become EMPTY next cycle, even if firing.
//   A fire in the flush cycle still counts. RS contents are not touched (flushed by owner).
//  issue_cnt adds (lane0 fire + lane1 fire) each cycle and saturates at 2^CNT_W-1.
//  Async reset mid-operation clears all lanes immediately.
//   First pop is possible in the first cycle after rst deasserts.
//  Outputs are X-free while valid=0 (the uop register holds its last or reset value).
// TESTING
//  1. RS has 3 entries A,B,C; both readies=1 -> cycle1: pop0=pop1=1, lanes A/B next cycle;
//     cycle2: pop0 only, lane0=C, lane1 empty; issue_cnt reaches 3.
//  2. RS 1 entry (1left_to_empty=1), lanes empty -> pop0=1, pop1=0; lane0 gets head next cycle.
//  3. Both lanes FULL, lane0_ready=0, lane1_ready=1, RS has 2 entries ->
//     pop0=1 only; head loads lane1; lane0 uop unchanged.
//  4. Lanes FULL, flush=1 with RS nonempty -> pops=0; both valids 0 next cycle.
//  5. Reset asserted mid-stream with valids=1 -> valids and issue_cnt drop to 0 without a clock edge.
//  6. CNT_W=2, fire 5 uops -> issue_cnt saturates at 3. RS empty: pops stay 0 for 100 random-ready cycles.

Source files
------------

// File: rtl/rvv_alu_rs_issue_if.sv
// Handshake bundle between the ALU reservation station, the issue stage and the two ALU lanes.
// The issue stage (rvv_alu_rs_issue) uses the master modport.
interface rvv_alu_rs_issue_if #(
  parameter int DWIDTH = 64
);
  logic [DWIDTH-1:0] alu_uop0_rs2ex;
  logic [DWIDTH-1:0] alu_uop1_rs2ex;
  logic              fifo_empty_rs2ex;
  logic              fifo_1left_to_empty_rs2ex;
  logic              pop0_ex2rs;
  logic              pop1_ex2rs;
  logic              flush;
  logic              lane0_valid;
  logic              lane1_valid;
  logic [DWIDTH-1:0] lane0_uop;
  logic [DWIDTH-1:0] lane1_uop;
  logic              lane0_ready;
  logic              lane1_ready;

  modport master (
    input  alu_uop0_rs2ex, alu_uop1_rs2ex, fifo_empty_rs2ex, fifo_1left_to_empty_rs2ex,
    input  flush, lane0_ready, lane1_ready,
    output pop0_ex2rs, pop1_ex2rs, lane0_valid, lane1_valid, lane0_uop, lane1_uop
  );

  modport slave (
    output alu_uop0_rs2ex, alu_uop1_rs2ex, fifo_empty_rs2ex, fifo_1left_to_empty_rs2ex,
    output flush, lane0_ready, lane1_ready,
    input  pop0_ex2rs, pop1_ex2rs, lane0_valid, lane1_valid, lane0_uop, lane1_uop
  );
endinterface

// File: rtl/rvv_alu_rs_issue.sv
// Reads the two oldest ALU reservation-station entries into two registered issue lanes.
// state | meaning:  EMPTY | lane holds no uop;  FULL | lane presents a uop to its ALU.
module rvv_alu_rs_issue #(
  parameter int DWIDTH = 64,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  rvv_alu_rs_issue_if.master rs,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_state_t;

  lane_state_t       state_q [2];
  lane_state_t       state_d [2];
  logic [DWIDTH-1:0] uop_q   [2];
  logic [DWIDTH-1:0] uop_d   [2];
  logic [1:0]        ready;
  logic [1:0]        fire;
  logic [1:0]        free;
  logic [1:0]        avail;
  logic [1:0]        nfree;
  logic [1:0]        n;
  logic [CNT_W:0]    cnt_sum;

  assign ready = {rs.lane1_ready, rs.lane0_ready};

  always_comb begin
    fire  = '0;
    free  = '0;
    for (int i = 0; i < 2; i++) begin
      fire[i] = (state_q[i] == FULL) && ready[i];
      free[i] = (state_q[i] == EMPTY) || fire[i];
    end
    avail = rs.fifo_empty_rs2ex ? 2'd0 : (rs.fifo_1left_to_empty_rs2ex ? 2'd1 : 2'd2);
    nfree = {1'b0, free[0]} + {1'b0, free[1]};
    n     = rs.flush ? 2'd0 : ((nfree < avail) ? nfree : avail);
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = fire[i] ? EMPTY : state_q[i];
      uop_d[i]   = uop_q[i];
    end
    if (rs.flush) begin
      state_d[0] = EMPTY;
      state_d[1] = EMPTY;
    end else if (n == 2'd2) begin
      state_d[0] = FULL;
      state_d[1] = FULL;
      uop_d[0]   = rs.alu_uop0_rs2ex;
      uop_d[1]   = rs.alu_uop1_rs2ex;
    end else if (n == 2'd1) begin
      // single entry goes to the lowest free lane, which may be one that fires now
      if (free[0]) begin
        state_d[0] = FULL;
        uop_d[0]   = rs.alu_uop0_rs2ex;
      end else begin
        state_d[1] = FULL;
        uop_d[1]   = rs.alu_uop0_rs2ex;
      end
    end
  end

  assign cnt_sum = {1'b0, issue_cnt} + (CNT_W+1)'(fire[0]) + (CNT_W+1)'(fire[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= EMPTY;
        uop_q[i]   <= '0;
      end
      issue_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        uop_q[i]   <= uop_d[i];
      end
      issue_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  assign rs.pop0_ex2rs  = !rst && (n != 2'd0);
  assign rs.pop1_ex2rs  = !rst && (n == 2'd2);
  assign rs.lane0_valid = (state_q[0] == FULL);
  assign rs.lane1_valid = (state_q[1] == FULL);
  assign rs.lane0_uop   = uop_q[0];
  assign rs.lane1_uop   = uop_q[1];

endmodule

// File: tb/tb_rvv_alu_rs_issue.sv
// Bench for rvv_alu_rs_issue: directed scenarios then random traffic against a queue-based model.
module tb_rvv_alu_rs_issue;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cnt_a;
  logic [1:0]    cnt_b;

  rvv_alu_rs_issue_if #(.DWIDTH(DW)) ifa ();
  rvv_alu_rs_issue_if #(.DWIDTH(DW)) ifb ();

  rvv_alu_rs_issue #(.DWIDTH(DW), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .rs(ifa), .issue_cnt(cnt_a));
  rvv_alu_rs_issue #(.DWIDTH(DW), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .rs(ifb), .issue_cnt(cnt_b));

  assign ifb.alu_uop0_rs2ex            = ifa.alu_uop0_rs2ex;
  assign ifb.alu_uop1_rs2ex            = ifa.alu_uop1_rs2ex;
  assign ifb.fifo_empty_rs2ex          = ifa.fifo_empty_rs2ex;
  assign ifb.fifo_1left_to_empty_rs2ex = ifa.fifo_1left_to_empty_rs2ex;
  assign ifb.flush                     = ifa.flush;
  assign ifb.lane0_ready               = ifa.lane0_ready;
  assign ifb.lane1_ready               = ifa.lane1_ready;

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] q [$];
  logic        mv [2];
  logic [15:0] mu [2];
  int          mcnt;
  int          mcnt2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv[0] = 1'b0; mv[1] = 1'b0;
    mu[0] = '0;   mu[1] = '0;
    mcnt = 0; mcnt2 = 0;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic fl);
    ifa.lane0_ready               = r0;
    ifa.lane1_ready               = r1;
    ifa.flush                     = fl;
    ifa.fifo_empty_rs2ex          = (q.size() == 0);
    ifa.fifo_1left_to_empty_rs2ex = (q.size() == 1);
    ifa.alu_uop0_rs2ex            = (q.size() > 0) ? q[0] : 16'($urandom);
    ifa.alu_uop1_rs2ex            = (q.size() > 1) ? q[1] : 16'($urandom);
  endtask

  // One clock cycle: check pops before the edge, advance the model, check lanes after.
  task automatic step(input logic r0, input logic r1, input logic fl);
    logic rdy [2];
    logic fr  [2];
    logic fre [2];
    int   avail, nf, n, take, fires;
    rdy[0] = r0; rdy[1] = r1;
    drive(r0, r1, fl);
    #1;
    avail = (q.size() > 2) ? 2 : q.size();
    nf = 0; fires = 0;
    for (int i = 0; i < 2; i++) begin
      fr[i]  = mv[i] && rdy[i];
      fre[i] = !mv[i] || fr[i];
      nf    += int'(fre[i]);
      fires += int'(fr[i]);
    end
    n = fl ? 0 : ((nf < avail) ? nf : avail);
    chk("pop0", ifa.pop0_ex2rs, n >= 1);
    chk("pop1", ifa.pop1_ex2rs, n == 2);
    chk("pop0_b", ifb.pop0_ex2rs, n >= 1);
    @(posedge clk);
    mcnt  = (mcnt + fires > 65535) ? 65535 : mcnt + fires;
    mcnt2 = (mcnt2 + fires > 3) ? 3 : mcnt2 + fires;
    take = 0;
    for (int i = 0; i < 2; i++) begin
      if (fl) mv[i] = 1'b0;
      else if (fre[i] && take < n) begin
        mu[i] = q[take];
        mv[i] = 1'b1;
        take++;
      end else if (fr[i]) mv[i] = 1'b0;
    end
    repeat (take) void'(q.pop_front());
    #1;
    chk("lane0_valid", ifa.lane0_valid, mv[0]);
    chk("lane1_valid", ifa.lane1_valid, mv[1]);
    chk("lane0_uop", ifa.lane0_uop, mu[0]);
    chk("lane1_uop", ifa.lane1_uop, mu[1]);
    chk("issue_cnt", cnt_a, mcnt);
    chk("issue_cnt_sat", cnt_b, mcnt2);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid0", ifa.lane0_valid, 1'b0);
    chk("rst_valid1", ifa.lane1_valid, 1'b0);
    chk("rst_uop0", ifa.lane0_uop, 16'h0);
    chk("rst_cnt", cnt_a, 0);
    rst = 1'b0;

    // Three entries, both lanes ready
    q = '{16'h00A1, 16'h00B2, 16'h00C3};
    step(1'b1, 1'b1, 1'b0);
    chk("t1_lane0", ifa.lane0_uop, 16'h00A1);
    chk("t1_lane1", ifa.lane1_uop, 16'h00B2);
    step(1'b1, 1'b1, 1'b0);
    chk("t1_lane0_c", ifa.lane0_uop, 16'h00C3);
    chk("t1_lane1_empty", ifa.lane1_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t1_cnt3", cnt_a, 3);

    // Single entry, lanes empty
    q = '{16'h00D4};
    step(1'b1, 1'b1, 1'b0);
    chk("t2_lane0", ifa.lane0_uop, 16'h00D4);
    step(1'b1, 1'b1, 1'b0);

    // Lane0 stalled, lane1 draining, two entries waiting
    q = '{16'h0E01, 16'h0E02};
    step(1'b0, 1'b0, 1'b0);
    q = '{16'h0F01, 16'h0F02};
    step(1'b0, 1'b1, 1'b0);
    chk("t3_lane0_hold", ifa.lane0_uop, 16'h0E01);
    chk("t3_lane1_new", ifa.lane1_uop, 16'h0F01);

    // Flush with RS nonempty and lane0 firing
    q.push_back(16'h0F03);
    step(1'b1, 1'b0, 1'b1);
    chk("t4_valid0", ifa.lane0_valid, 1'b0);
    chk("t4_valid1", ifa.lane1_valid, 1'b0);

    // Async reset with both lanes full
    step(1'b0, 1'b0, 1'b0);
    q = '{16'h0A01, 16'h0A02};
    drive(1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid0", ifa.lane0_valid, 1'b0);
    chk("t5_valid1", ifa.lane1_valid, 1'b0);
    chk("t5_cnt", cnt_a, 0);
    chk("t5_pop0", ifa.pop0_ex2rs, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);

    // Empty RS with random readies
    q.delete();
    repeat (100) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    // Random traffic with occasional flushes
    repeat (300) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) if (q.size() < 6) q.push_back(16'($urandom));
    end
    if (mcnt >= 3) chk("sat_cnt2", cnt_b, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
